// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// FSM encodings, register-number width and the per-stage control bundle.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2,
      ST_BAD  = 2'd3
   } hz_state_e;

   typedef struct packed {
      logic pc_write;
      logic pc_sel_branch;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_flush;
      logic exmem_write;
      logic exmem_flush;
      logic memwb_flush;
   } hz_ctrl_t;

   // Everything frozen, nothing squashed: reset, halt and illegal-state pattern.
   function automatic hz_ctrl_t ctrl_idle();
      hz_ctrl_t c;
      c = '0;
      return c;
   endfunction

   function automatic hz_ctrl_t ctrl_normal();
      hz_ctrl_t c;
      c             = '0;
      c.pc_write    = 1'b1;
      c.ifid_write  = 1'b1;
      c.idex_write  = 1'b1;
      c.exmem_write = 1'b1;
      return c;
   endfunction

   // Front of the pipe frozen; WB is flushed so its instruction retires only once.
   function automatic hz_ctrl_t ctrl_mem_wait();
      hz_ctrl_t c;
      c             = '0;
      c.memwb_flush = 1'b1;
      return c;
   endfunction

   // Redirect fetch and squash the three younger instructions.
   function automatic hz_ctrl_t ctrl_branch();
      hz_ctrl_t c;
      c               = ctrl_normal();
      c.pc_sel_branch = 1'b1;
      c.ifid_flush    = 1'b1;
      c.idex_flush    = 1'b1;
      c.exmem_flush   = 1'b1;
      return c;
   endfunction

   // Hold PC and IF/ID, inject one bubble into ID/EX; older stages advance.
   function automatic hz_ctrl_t ctrl_load_use();
      hz_ctrl_t c;
      c             = ctrl_normal();
      c.pc_write    = 1'b0;
      c.ifid_write  = 1'b0;
      c.idex_flush  = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detect between the ID and EX stages.
// A load into $0 never creates a dependency.
module load_use_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   output logic             lu
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_uses_rs & (ex_rt == id_rs);
   assign rt_hit = id_uses_rt & (ex_rt == id_rt);
   assign lu     = ex_memread & (ex_rt != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// squashes and dmem wait with a timeout halt. Optional counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 64,
   parameter int unsigned WAIT_W   = 7,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             mem_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             pc_sel_branch,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] br_flush_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

   localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("pipe_hazard_ctrl: MAX_WAIT must be at least 1");
   end
   if ((64'd1 << WAIT_W) <= 64'(MAX_WAIT)) begin : g_bad_wait_w
      $error("pipe_hazard_ctrl: WAIT_W too narrow for MAX_WAIT");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_hazard_ctrl: CNT_W must be at least 1");
   end

   hz_state_e         state;
   hz_state_e         state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   hz_ctrl_t          ctrl;

   logic lu;
   logic mw;
   logic active;
   logic take_mw;
   logic take_br;
   logic take_lu;

   load_use_detect u_lu (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .lu         (lu)
   );

   // Event priority: memory wait, then branch, then load-use.
   assign mw      = mem_access & ~dmem_ready;
   assign active  = (state == ST_RUN) | (state == ST_WAIT);
   assign take_mw = active & mw;
   assign take_br = active & ~mw & mem_branch_taken;
   assign take_lu = active & ~mw & ~mem_branch_taken & lu;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         halted   <= (state_nxt == ST_HALT);
      end
   end

   // Wait counter counts consecutive stalled cycles; timeout only from WAIT.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         ST_RUN, ST_WAIT: begin
            if (mw) begin
               wait_cnt_nxt = (wait_cnt >= WAIT_SAT) ? wait_cnt : wait_cnt + WAIT_W'(1);
               if ((state == ST_WAIT) && (wait_cnt >= WAIT_LAST)) begin
                  state_nxt = ST_HALT;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end else begin
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      ctrl = ctrl_idle();
      if (!rst && active) begin
         if (take_mw) begin
            ctrl = ctrl_mem_wait();
         end else if (take_br) begin
            ctrl = ctrl_branch();
         end else if (take_lu) begin
            ctrl = ctrl_load_use();
         end else begin
            ctrl = ctrl_normal();
         end
      end
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_sel_branch = ctrl.pc_sel_branch;
   assign ifid_write    = ctrl.ifid_write;
   assign ifid_flush    = ctrl.ifid_flush;
   assign idex_write    = ctrl.idex_write;
   assign idex_flush    = ctrl.idex_flush;
   assign exmem_write   = ctrl.exmem_write;
   assign exmem_flush   = ctrl.exmem_flush;
   assign memwb_flush   = ctrl.memwb_flush;
   assign state_o       = state;

`ifdef HAZARD_PERF_CNT_EN
   // Event counters wrap naturally at CNT_W bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         lu_stall_cnt <= '0;
         br_flush_cnt <= '0;
         mem_wait_cnt <= '0;
      end else begin
         if (take_lu) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
         if (take_br) br_flush_cnt <= br_flush_cnt + CNT_W'(1);
         if (take_mw) mem_wait_cnt <= mem_wait_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed plan scenarios then random traffic,
// all checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned MW = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rs, id_uses_rt, ex_memread;
   logic       mem_branch_taken, mem_access, dmem_ready;
   logic       pc_write, pc_sel_branch, ifid_write, ifid_flush;
   logic       idex_write, idex_flush, exmem_write, exmem_flush, memwb_flush;
   logic       halted;
   logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: length of the current run of stalled memory cycles,
   // the sticky halt flag and event tallies.
   int m_run    = 0;
   bit m_halted = 1'b0;
   int m_lu     = 0;
   int m_br     = 0;
   int m_mw     = 0;

   localparam logic [8:0] P_IDLE   = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] P_NORMAL = 9'b1_0_1_0_1_0_1_0_0;
   localparam logic [8:0] P_MW     = 9'b0_0_0_0_0_0_0_0_1;
   localparam logic [8:0] P_BR     = 9'b1_1_1_1_1_1_1_1_0;
   localparam logic [8:0] P_LU     = 9'b0_0_0_0_1_1_1_0_0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MAX_WAIT(MW), .WAIT_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt),
      .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush),
      .exmem_write(exmem_write), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .halted(halted), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
      , .lu_stall_cnt(lu_stall_cnt), .br_flush_cnt(br_flush_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit f_lu();
      return ex_memread && (ex_rt != 5'd0) &&
             ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
   endfunction

   function automatic bit f_mw();
      return mem_access && !dmem_ready;
   endfunction

   function automatic logic [8:0] model_ctrl();
      if (rst || m_halted) return P_IDLE;
      if (f_mw())          return P_MW;
      if (mem_branch_taken) return P_BR;
      if (f_lu())          return P_LU;
      return P_NORMAL;
   endfunction

   // One clock: compare at negedge, then advance the model across posedge.
   task automatic cycle(input string tag, input bit use_lit, input logic [8:0] lit);
      logic [8:0] obs;
      @(negedge clk);
      obs = {pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write,
             idex_flush, exmem_write, exmem_flush, memwb_flush};
      check({tag, "_ctrl"}, 32'(obs), 32'(model_ctrl()));
      if (use_lit) check({tag, "_plan"}, 32'(obs), 32'(lit));
      check({tag, "_state"}, 32'(state_o), m_halted ? 32'd2 : (m_run > 0 ? 32'd1 : 32'd0));
      check({tag, "_halted"}, 32'(halted), 32'(m_halted));
`ifdef HAZARD_PERF_CNT_EN
      check({tag, "_lucnt"}, 32'(lu_stall_cnt), 32'(m_lu));
      check({tag, "_brcnt"}, 32'(br_flush_cnt), 32'(m_br));
      check({tag, "_mwcnt"}, 32'(mem_wait_cnt), 32'(m_mw));
`endif
      @(posedge clk);
      if (rst) begin
         m_run = 0; m_halted = 1'b0; m_lu = 0; m_br = 0; m_mw = 0;
      end else if (!m_halted) begin
         if (f_mw()) begin
            m_mw++;
            m_run++;
            if (m_run >= MW) m_halted = 1'b1;
         end else begin
            m_run = 0;
            if (mem_branch_taken) m_br++;
            else if (f_lu()) m_lu++;
         end
      end
      #1;
   endtask

   function automatic logic [4:0] rnd_reg();
      case ($urandom % 4)
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd5;
         default: return 5'd31;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      id_rs = '0; id_rt = '0; ex_rt = '0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
      mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
      cycle("reset0", 1'b1, P_IDLE);
      cycle("reset1", 1'b1, P_IDLE);
      rst = 1'b0;
      cycle("idle_run", 1'b1, P_NORMAL);

      // load-use: one bubble, then EX holds the bubble
      ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      cycle("lu_stall", 1'b1, P_LU);
      ex_memread = 1'b0; ex_rt = 5'd0;
      cycle("lu_after", 1'b1, P_NORMAL);

      // load into $0 never stalls
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      cycle("lu_zero", 1'b1, P_NORMAL);

      // taken branch beats a simultaneous load-use
      ex_rt = 5'd5; id_rs = 5'd5; mem_branch_taken = 1'b1;
      cycle("br_lu", 1'b1, P_BR);
      mem_branch_taken = 1'b0; ex_memread = 1'b0; id_uses_rs = 1'b0;
      cycle("br_after", 1'b1, P_NORMAL);

      // three wait cycles then release
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle("mw3", 1'b1, P_MW);
      dmem_ready = 1'b1;
      cycle("mw_release", 1'b1, P_NORMAL);
      mem_access = 1'b0;
      cycle("mw_back_run", 1'b1, P_NORMAL);

      // timeout halt, frozen until reset
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < int'(MW); i++) cycle("to_wait", 1'b1, P_MW);
      for (int i = 0; i < 3; i++) cycle("halt", 1'b1, P_IDLE);
      dmem_ready = 1'b1; mem_branch_taken = 1'b1;
      cycle("halt_ignores", 1'b1, P_IDLE);
      mem_branch_taken = 1'b0; mem_access = 1'b0;
      rst = 1'b1;
      cycle("halt_rst", 1'b1, P_IDLE);
      rst = 1'b0;
      cycle("post_halt", 1'b1, P_NORMAL);

      // reset in the middle of a wait
      mem_access = 1'b1; dmem_ready = 1'b0;
      cycle("pre_rst_wait", 1'b1, P_MW);
      rst = 1'b1;
      cycle("rst_in_wait", 1'b1, P_IDLE);
      rst = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
      cycle("after_rst_wait", 1'b1, P_NORMAL);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         rst              = ($urandom % 40) == 0;
         id_rs            = rnd_reg();
         id_rt            = rnd_reg();
         ex_rt            = rnd_reg();
         id_uses_rs       = 1'($urandom % 2);
         id_uses_rt       = 1'($urandom % 2);
         ex_memread       = 1'($urandom % 2);
         mem_branch_taken = ($urandom % 5) == 0;
         mem_access       = 1'($urandom % 2);
         dmem_ready       = 1'($urandom % 2);
         cycle("rand", 1'b0, P_IDLE);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives write-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three cases:
- Load-use stalls, detected between ID and EX.
- Taken-branch flushes, resolved in MEM.
- Multi-cycle data-memory waits, handled with a watchdog that halts the pipeline on timeout.

Parameters:
MAX_WAIT, 64, max consecutive dmem wait cycles before timeout halt (must be >= 1)
WAIT_W, 7, width of wait counter; must satisfy 2^WAIT_W > MAX_WAIT
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  MemRead of the instruction in EX
ex_rt  in  5  rt (load destination) of the instruction in EX
mem_branch_taken  in  1  Branch & zero, from the instruction in MEM
mem_access  in  1  MemRead | MemWrite of the instruction in MEM
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
pc_sel_branch  out  1  select branch target into PC
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a bubble
idex_write  out  1  ID/EX load enable
idex_flush  out  1  ID/EX control fields load zero (bubble)
exmem_write  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM control fields load zero
memwb_flush  out  1  MEM/WB control fields load zero
halted  out  1  sticky: timeout occurred, pipeline frozen
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states:
  - RUN=2'd0
  - WAIT=2'd1
  - HALT=2'd2
  - 2'd3 is illegal and recovers to RUN on the next clock.
- Reset: state=RUN, wait counter=0, halted=0.
- Control outputs are combinational from state and inputs. While rst=1, the control outputs are forced to the idle pattern:
  - pc_write=0, ifid_write=0, idex_write=0, exmem_write=0
  - all flushes=0, pc_sel_branch=0
- Definitions:
  - lu = ex_memread & (ex_rt!=0) & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))
  - mw = mem_access & ~dmem_ready
- Priority in RUN/WAIT: mw > mem_branch_taken > lu > normal.
- Normal (no event): all *_write=1, all flushes=0, pc_sel_branch=0.
- mw (memory wait):
  - pc_write, ifid_write, idex_write, exmem_write = 0 (freeze).
  - memwb_flush=1, so the WB instruction retires exactly once.
  - Next state WAIT; the counter increments, saturating at MAX_WAIT.
- WAIT with dmem_ready=1: normal pattern this cycle, next state RUN, counter cleared.
- Timeout: in WAIT, when the counter reaches MAX_WAIT-1 and mw is still 1, next state is HALT.
- Branch taken:
  - pc_write=1, pc_sel_branch=1.
  - ifid_flush=1, idex_flush=1, exmem_flush=1; all writes=1.
  - Three younger instructions are squashed. Zero-cycle latency (same cycle).
- Load-use hazard:
  - pc_write=0, ifid_write=0, idex_flush=1; exmem/memwb advance.
  - Exactly one bubble; the next cycle re-evaluates, and lu is 0 because EX now holds the bubble.
- Load into $0: never stalls.
- mw together with mem_branch_taken is architecturally impossible. If it occurs, mw wins and the branch is applied on the release cycle.
- HALT:
  - All *_write=0, all flushes=0, halted=1.
  - Only rst exits.
- Reset mid-WAIT returns to RUN with the counter at 0. The memory request is abandoned; no handshake is owed.

Optional Feature:
Macro HAZARD_PERF_CNT_EN. When defined, three extra output ports are added, each CNT_W bits wide, wrapping, reset to 0:
- lu_stall_cnt: +1 per load-use bubble.
- br_flush_cnt: +1 per taken-branch flush.
- mem_wait_cnt: +1 per mw cycle, including the timeout cycle.
When undefined, the ports and logic are absent and the core behaviour is unchanged.

Decomposition:
- Shared package: state encodings (ST_RUN/ST_WAIT/ST_HALT), register-number width 5, zero-register constant.
- One natural sub-module, load_use_detect: purely combinational lu computation, reusable by the forwarding unit.

Test Plan:
1. lw $5,0($1) in EX with ex_memread=1, ex_rt=5; ID add uses rs=5 (id_uses_rs=1) -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle all writes=1.
2. ex_rt=0, ex_memread=1, id_rs=0, id_uses_rs=1 -> no stall; all writes=1.
3. mem_branch_taken=1 in RUN -> pc_sel_branch=1, ifid_flush=idex_flush=exmem_flush=1 for one cycle; with lu=1 simultaneously the branch response wins.
4. mem_access=1, dmem_ready held low 3 cycles then high -> 3 freeze cycles (state WAIT after the first, memwb_flush=1), release cycle normal, state RUN; with the feature, mem_wait_cnt=3.
5. MAX_WAIT=4, dmem_ready held low -> halted=1 and state HALT after 4 wait cycles; writes stay 0 until rst, which restores RUN with halted=0.
6. rst asserted during WAIT -> next cycle state=RUN, counter 0, all outputs at their reset pattern while rst is high.
